bq_sched: RTL and testbench
===========================

# bq_sched

Time-multiplexing scheduler that shares one multi-context biquad engine among NCH sample requesters. Per-channel filter state lives in the engine and is selected by a context index. The block arbitrates requesters round-robin and issues one sample per transaction as a single-cycle valid pulse with its context. It captures the engine result a fixed LAT cycles later and returns it, tagged with the channel, over a valid/ready response port. It sits between the channel sample sources and the biquad datapath, in the filter clock domain.

## Interface
- DATAWIDTH, 16, sample width (x and y)
- NCH, 4, number of requesting channels (2..16)
- CHW, 2, channel/context index width, equal to clog2(NCH)
- LAT, 3, engine latency in cycles from issue to result valid (≥1)

- bq_clk_i  in  1  filter clock; all logic on rising edge
- nreset  in  1  asynchronous active-low reset
- enable_i  in  1  global grant enable
- ch_en_i  in  NCH  per-channel grant mask
- req_valid_i  in  NCH  per-channel sample valid
- req_data_i  in  NCH*DATAWIDTH  samples; channel k occupies bits [k*DATAWIDTH +: DATAWIDTH]
- req_ready_o  out  NCH  one-hot accept strobe
- eng_valid_o  out  1  engine issue pulse
- eng_x_o  out  DATAWIDTH  sample to engine
- eng_ctx_o  out  CHW  engine context select
- eng_y_i  in  DATAWIDTH  engine result
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_ch_o  out  CHW  response channel
- rsp_data_o  out  DATAWIDTH  filtered sample
- busy_o  out  1  transaction in progress

## Operation
- Reset (async, nreset=0): state=IDLE, rr pointer=NCH-1. All outputs are 0: req_ready_o, eng_valid_o, eng_x_o, eng_ctx_o, rsp_valid_o, rsp_ch_o, rsp_data_o, busy_o. An in-flight transaction is discarded.
- Eligible set: req_valid_i & ch_en_i, qualified by enable_i.
- **IDLE**
  - If the eligible set is non-empty, grant g = the first eligible channel searching upward from pointer+1, modulo NCH.
  - Combinationally in that cycle: req_ready_o[g]=1, other bits 0.
  - At the clock edge: register sample, register ctx=g, pointer←g, go to ISSUE.
  - If the eligible set is empty, stay in IDLE with req_ready_o=0.
- **ISSUE**: eng_valid_o=1 for exactly this cycle, with eng_x_o and eng_ctx_o driven from registers. Load cnt=LAT and go to WAIT.
- **WAIT**: decrement cnt each cycle. When cnt==1, capture eng_y_i into rsp_data_o at that edge, set rsp_ch_o=ctx, and go to RESP.
- **RESP**: rsp_valid_o=1. rsp_data_o and rsp_ch_o are held stable until rsp_ready_i=1. On the handshake edge, rsp_valid_o←0 and state goes to IDLE. No grant is made in this cycle.
- eng_x_o and eng_ctx_o hold their last issued values outside ISSUE. The engine must sample them only when eng_valid_o=1.
- busy_o = (state ≠ IDLE).
- enable_i and ch_en_i affect grants only. Deasserting either never aborts an in-flight transaction.
- req_data_i of non-granted channels is ignored. A requester holds its sample until it sees its req_ready_o bit high.

## Timing
- Let the accept cycle be t (IDLE with req_ready_o[g]=1).
  - ISSUE occupies cycle t+1.
  - eng_y_i is sampled at the end of cycle t+1+LAT.
  - rsp_valid_o first rises in cycle t+2+LAT.
- Best-case throughput, with rsp_ready_i held at 1: one sample per LAT+3 cycles (6 cycles at LAT=3).
- With continuous requests, the round-robin order is strict. Every eligible channel is served within NCH transactions, so there is no starvation.
- A request arriving during ISSUE, WAIT or RESP waits for the next IDLE.
- Releasing reset mid-stream: the first grant goes to the lowest-index eligible channel.

## Structure
- Package bq_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the cnt width function clog2(LAT+1);
  - the default parameter constants.
- Sub-module bq_rr_arb: combinational round-robin arbiter, parameterised by NCH. Inputs are the eligible mask and the pointer; outputs are the one-hot grant, the encoded index and any-valid.
- The top level bq_sched contains the FSM, counter, data/ctx registers and the response register.

## Test plan
- **Single request:** ch2 presents 0x1234 and the engine model returns x+1 after LAT=3, with rsp_ready_i=1.
  - Required: eng_ctx_o=2 during ISSUE.
  - Required: rsp_ch_o=2 and rsp_data_o=0x1235, with rsp_valid_o rising 5 cycles after the accept.
- **Full load:** all four channels held valid, rsp_ready_i=1.
  - Required: grants in the order 0,1,2,3,0,1 with exactly 6 cycles between successive req_ready_o pulses.
- **Backpressure:** rsp_ready_i=0 for 10 cycles while in RESP.
  - Required: rsp_valid_o, rsp_ch_o and rsp_data_o stay stable, and no req_ready_o is asserted.
  - Required: after rsp_ready_i goes to 1, the next grant occurs 1 cycle after the handshake.
- **Masking:** ch_en_i=4'b1010 with all channels valid.
  - Required: only channels 1 and 3 are served, alternating.
  - Required: channels 0 and 2 never see req_ready_o.
- **Reset mid-WAIT:** nreset asserted for 2 cycles.
  - Required: all outputs are 0 immediately, without waiting for a clock edge, and no response is emitted.
  - Required: after release with all channels valid, ch0 is granted first.
- **Enable drop:** enable_i→0 during WAIT.
  - Required: the in-flight response is still delivered correctly.
  - Required: no further req_ready_o while enable_i=0, and grants resume on the first IDLE cycle after enable_i returns to 1.

Source files
------------

// File: rtl/bq_sched_pkg.sv
// Shared types and constants for the biquad engine scheduler.
// State encoding, counter sizing helper and default parameter values.
package bq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_NCH       = 4;
    localparam int DEF_CHW       = 2;
    localparam int DEF_LAT       = 3;

    // Width of a down-counter that must hold the value lat.
    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/bq_rr_arb.sv
// Combinational round-robin arbiter: picks the first eligible channel
// searching upward from ptr+1, wrapping modulo NCH.
module bq_rr_arb
    import bq_sched_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CHW = DEF_CHW
) (
    input  logic [NCH-1:0] elig,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] grant,
    output logic [CHW-1:0] idx,
    output logic           any
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= NCH; i++) begin
            j = (int'(ptr) + i) % NCH;
            if (!found && elig[j]) begin
                grant[j] = 1'b1;
                idx      = CHW'(j);
                found    = 1'b1;
            end
        end
    end

    assign any = |elig;

endmodule

// File: rtl/bq_sched.sv
// Time-multiplexing scheduler sharing one multi-context biquad engine
// among NCH requesters: round-robin grant, fixed-latency capture, valid/ready return.
module bq_sched
    import bq_sched_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int NCH       = DEF_NCH,
    parameter int CHW       = DEF_CHW,
    parameter int LAT       = DEF_LAT
) (
    input  logic                     bq_clk_i,
    input  logic                     nreset,
    input  logic                     enable_i,
    input  logic [NCH-1:0]           ch_en_i,
    input  logic [NCH-1:0]           req_valid_i,
    input  logic [NCH*DATAWIDTH-1:0] req_data_i,
    output logic [NCH-1:0]           req_ready_o,
    output logic                     eng_valid_o,
    output logic [DATAWIDTH-1:0]     eng_x_o,
    output logic [CHW-1:0]           eng_ctx_o,
    input  logic [DATAWIDTH-1:0]     eng_y_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [CHW-1:0]           rsp_ch_o,
    output logic [DATAWIDTH-1:0]     rsp_data_o,
    output logic                     busy_o
);

    localparam int CW = cnt_width(LAT);

    state_t         state, nxt_state;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] grant;
    logic [CHW-1:0] gidx;
    logic [CHW-1:0] ptr;
    logic           any;
    logic           accept;
    logic [CW-1:0]  cnt;

    assign elig = enable_i ? (req_valid_i & ch_en_i) : '0;

    bq_rr_arb #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .elig  (elig),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    always_ff @(posedge bq_clk_i or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    accept    = 1'b1;
                    nxt_state = ISSUE;
                end
            end
            ISSUE: nxt_state = WAIT;
            WAIT:  if (cnt == CW'(1)) nxt_state = RESP;
            RESP:  if (rsp_ready_i) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Gated by nreset so the strobe is silent while reset is held, even though
    // the state already reads IDLE.
    assign req_ready_o = (accept && nreset) ? grant : '0;
    assign eng_valid_o = (state == ISSUE);
    assign rsp_valid_o = (state == RESP);
    assign busy_o      = (state != IDLE);

    always_ff @(posedge bq_clk_i or negedge nreset) begin
        if (!nreset) begin
            ptr        <= CHW'(NCH - 1);
            eng_x_o    <= '0;
            eng_ctx_o  <= '0;
            cnt        <= '0;
            rsp_ch_o   <= '0;
            rsp_data_o <= '0;
        end else begin
            if (accept) begin
                eng_x_o   <= req_data_i[int'(gidx)*DATAWIDTH +: DATAWIDTH];
                eng_ctx_o <= gidx;
                ptr       <= gidx;
            end
            if (state == ISSUE) cnt <= CW'(LAT);
            // Engine result is valid in the last WAIT cycle; rsp regs then hold through RESP.
            if (state == WAIT) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    rsp_data_o <= eng_y_i;
                    rsp_ch_o   <= eng_ctx_o;
                end
            end
        end
    end

endmodule

// File: tb/tb_bq_sched.sv
// Directed self-checking bench for bq_sched with a fixed-latency x+1 engine model.
module tb_bq_sched;

    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              nreset;
    logic              enable;
    logic [NCH-1:0]    ch_en;
    logic [NCH-1:0]    req_valid;
    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    req_ready;
    logic              eng_valid;
    logic [DW-1:0]     eng_x;
    logic [CHW-1:0]    eng_ctx;
    logic [DW-1:0]     eng_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [CHW-1:0]    rsp_ch;
    logic [DW-1:0]     rsp_data;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW-1:0] pipe [LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: y = x + 1 exactly LAT cycles after the issue pulse, junk otherwise.
    always @(posedge clk) begin
        pipe[0] <= eng_valid ? eng_x + 16'd1 : 16'hDEAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign eng_y = pipe[LAT-1];

    bq_sched #(.DATAWIDTH(DW), .NCH(NCH), .CHW(CHW), .LAT(LAT)) dut (
        .bq_clk_i    (clk),
        .nreset      (nreset),
        .enable_i    (enable),
        .ch_en_i     (ch_en),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .eng_valid_o (eng_valid),
        .eng_x_o     (eng_x),
        .eng_ctx_o   (eng_ctx),
        .eng_y_i     (eng_y),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_ch_o    (rsp_ch),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input int budget, output logic [NCH-1:0] g, output int at);
        g  = '0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (req_ready !== '0) begin
                g  = req_ready;
                at = cyc;
                break;
            end
            nxt();
        end
    endtask

    task automatic wait_rsp(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            nxt();
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {21'd0, req_ready, eng_valid, eng_x, eng_ctx, rsp_valid, rsp_ch, rsp_data, busy};
    endfunction

    logic [DW-1:0]  d [NCH];
    logic [NCH-1:0] g;
    logic [NCH-1:0] exp_ord [6];
    logic [NCH-1:0] exp_mask [4];
    int             at, prev_at;
    bit             seen;
    logic [CHW-1:0] hold_ch;
    logic [DW-1:0]  hold_data;

    initial begin
        for (int k = 0; k < NCH; k++) d[k] = 16'hA000 + 16'(k) * 16'h0111;
        exp_ord  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_mask = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

        nreset    = 1'b0;
        enable    = 1'b1;
        ch_en     = 4'b1111;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        nxt();
        nxt();
        chk("reset_outs", all_outs(), 64'd0);
        nreset = 1'b1;
        nxt();

        // Single request on ch2
        req_valid = 4'b0100;
        req_data  = {16'h5555, 16'h1234, 16'h7777, 16'h9999};
        #1;
        chk("single_ready", req_ready, 4'b0100);
        nxt();
        req_valid = '0;
        chk("single_issue_valid", eng_valid, 1'b1);
        chk("single_issue_ctx", eng_ctx, 2'd2);
        chk("single_issue_x", eng_x, 16'h1234);
        nxt();
        chk("single_t2_rsp", {eng_valid, rsp_valid, busy}, 3'b001);
        nxt();
        nxt();
        chk("single_t4_rsp", rsp_valid, 1'b0);
        nxt();
        chk("single_t5_rsp", {rsp_valid, rsp_ch, rsp_data}, {1'b1, 2'd2, 16'h1235});
        nxt();
        chk("single_t6_idle", {rsp_valid, busy}, 2'b00);

        // Fresh pointer, then full load
        nreset = 1'b0;
        nxt();
        nreset    = 1'b1;
        req_valid = 4'b1111;
        req_data  = {d[3], d[2], d[1], d[0]};
        #1;
        wait_grant(20, g, at);
        chk("full_grant0", g, exp_ord[0]);
        prev_at = at;
        for (int k = 1; k < 6; k++) begin
            nxt();
            wait_grant(20, g, at);
            chk($sformatf("full_grant%0d", k), g, exp_ord[k]);
            chk($sformatf("full_gap%0d", k), 64'(at - prev_at), 64'd6);
            prev_at = at;
        end

        // Backpressure on the ch1 response
        rsp_ready = 1'b0;
        nxt();
        wait_rsp(20, seen);
        chk("bp_rsp_seen", seen, 1'b1);
        chk("bp_rsp_val", {rsp_ch, rsp_data}, {2'd1, d[1] + 16'd1});
        hold_ch   = rsp_ch;
        hold_data = rsp_data;
        for (int k = 0; k < 10; k++) begin
            nxt();
            chk($sformatf("bp_hold%0d", k), {req_ready, rsp_valid, rsp_ch, rsp_data},
                {4'b0000, 1'b1, hold_ch, hold_data});
        end
        rsp_ready = 1'b1;
        nxt();
        chk("bp_regrant", {rsp_valid, req_ready}, {1'b0, 4'b0100});

        // Masking: only ch1/ch3 eligible
        nxt();
        ch_en = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            nxt();
            wait_grant(20, g, at);
            chk($sformatf("mask_grant%0d", k), g, exp_mask[k]);
        end

        // Reset while in WAIT
        nxt();
        nxt();
        nxt();
        chk("rst_pre_busy", {busy, eng_valid}, 2'b10);
        nreset = 1'b0;
        #1;
        chk("rst_async_outs", all_outs(), 64'd0);
        nxt();
        nxt();
        chk("rst_held_outs", all_outs(), 64'd0);
        ch_en  = 4'b1111;
        nreset = 1'b1;
        #1;
        chk("rst_first_grant", req_ready, 4'b0001);

        // Enable drop during WAIT
        nxt();
        chk("en_issue", {eng_valid, eng_ctx, eng_x}, {1'b1, 2'd0, d[0]});
        nxt();
        enable = 1'b0;
        wait_rsp(20, seen);
        chk("en_rsp_seen", seen, 1'b1);
        chk("en_rsp_val", {rsp_ch, rsp_data}, {2'd0, d[0] + 16'd1});
        for (int k = 0; k < 4; k++) begin
            nxt();
            chk($sformatf("en_off%0d", k), {req_ready, busy}, {4'b0000, 1'b0});
        end
        enable = 1'b1;
        #1;
        chk("en_resume", req_ready, 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
